// File: rtl/data_mem_responder.sv
// data_mem_responder: data-side memory model for a processor test harness.
// Serves loads from a word RAM, classifies stores to detect test completion
// (pass/fail with an error code), counts stores and records each one in a
// write-log FIFO that a consumer drains with a valid/ready handshake.
//
// state | meaning
// RUN   | test running; stores accepted, classified, counted and logged
// PASS  | expected value stored to the result address; terminal until reset
// FAIL  | bad result / out-of-range / misaligned store; terminal until reset
module data_mem_responder #(
    parameter int DEPTH     = 64,
    parameter int PASS_ADR  = 100,
    parameter int PASS_VAL  = 7,
    parameter int LOG_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        done,
    output logic        pass,
    output logic [1:0]  err_code,
    output logic [15:0] wr_count,
    output logic        log_valid,
    input  logic        log_ready,
    output logic [31:0] log_adr,
    output logic [31:0] log_data,
    output logic        log_overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;

    localparam logic [31:0] RAM_BYTES   = 32'(4 * DEPTH);
    localparam logic [31:0] PASS_ADR_W  = 32'(PASS_ADR);
    localparam logic [31:0] PASS_VAL_W  = 32'(PASS_VAL);
    localparam logic [LW:0] LOG_FULL    = (LW + 1)'(LOG_DEPTH);

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_VALUE = 2'd1;
    localparam logic [1:0] ERR_RANGE = 2'd2;
    localparam logic [1:0] ERR_ALIGN = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [15:0] wr_count_q, wr_count_d;
    logic [LW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW:0]   count_q, count_d;
    logic        overflow_q, overflow_d;

    logic [31:0] mem_q      [DEPTH];
    logic [31:0] log_adr_q  [LOG_DEPTH];
    logic [31:0] log_data_q [LOG_DEPTH];

    logic          in_range;
    logic [AW-1:0] word_idx;
    logic          store;
    logic          ram_we;
    logic          push_ok;
    logic          pop;
    logic          full;

    assign in_range = (DataAdr < RAM_BYTES);
    assign word_idx = DataAdr[AW+1:2];

    // Combinational load path; out-of-range addresses read as zero.
    always_comb begin
        ReadData = 32'd0;
        if (in_range) begin
            ReadData = mem_q[word_idx];
        end
    end

    assign store = (state_q == ST_RUN) && MemWrite;
    assign full  = (count_q == LOG_FULL);
    assign pop   = log_valid && log_ready;
    // A push into a full log still lands if the head leaves at the same edge.
    assign push_ok = store && (!full || pop);

    // Store classification, next state, error code and store counter.
    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        wr_count_d = wr_count_q;
        ram_we     = 1'b0;
        if (store) begin
            if (wr_count_q != 16'hFFFF) begin
                wr_count_d = wr_count_q + 16'd1;
            end
            if (DataAdr[1:0] != 2'b00) begin
                state_d    = ST_FAIL;
                err_code_d = ERR_ALIGN;
            end else if (DataAdr == PASS_ADR_W) begin
                if (WriteData == PASS_VAL_W) begin
                    state_d = ST_PASS;
                end else begin
                    state_d    = ST_FAIL;
                    err_code_d = ERR_VALUE;
                end
            end else if (!in_range) begin
                state_d    = ST_FAIL;
                err_code_d = ERR_RANGE;
            end else begin
                // Gated by reset so a store in flight during reset is dropped.
                ram_we = reset;
            end
        end
    end

    // Log FIFO pointer, occupancy and overflow next-state.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 1'b1;
        end
        if (store && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    // Control and log-pointer registers, cleared by asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            err_code_q <= ERR_NONE;
            wr_count_q <= 16'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
            wr_count_q <= wr_count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Data RAM; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_q[word_idx] <= WriteData;
        end
    end

    // Log entry storage; entries are only visible through the occupancy count,
    // so reset only needs to clear the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            log_adr_q[wr_ptr_q]  <= DataAdr;
            log_data_q[wr_ptr_q] <= WriteData;
        end
    end

    assign log_valid = (count_q != '0);

    // Head entry view; forced to zero whenever the log is empty.
    always_comb begin
        log_adr  = 32'd0;
        log_data = 32'd0;
        if (log_valid) begin
            log_adr  = log_adr_q[rd_ptr_q];
            log_data = log_data_q[rd_ptr_q];
        end
    end

    assign done         = (state_q != ST_RUN);
    assign pass         = (state_q == ST_PASS);
    assign err_code     = err_code_q;
    assign wr_count     = wr_count_q;
    assign log_overflow = overflow_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder with hand-computed expectations.
module tb_data_mem_responder;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        done;
    logic        pass;
    logic [1:0]  err_code;
    logic [15:0] wr_count;
    logic        log_valid;
    logic        log_ready;
    logic [31:0] log_adr;
    logic [31:0] log_data;
    logic        log_overflow;

    int n_checks;
    int n_errors;

    data_mem_responder #(
        .DEPTH(64), .PASS_ADR(100), .PASS_VAL(7), .LOG_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .ReadData(ReadData), .done(done), .pass(pass),
        .err_code(err_code), .wr_count(wr_count), .log_valid(log_valid),
        .log_ready(log_ready), .log_adr(log_adr), .log_data(log_data),
        .log_overflow(log_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reset pulse inside the low clock phase; operation resumes next posedge.
    task automatic do_reset();
        @(negedge clk);
        MemWrite  = 1'b0;
        log_ready = 1'b0;
        reset     = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    // One store strobe across a single rising edge; returns #1 after that edge.
    task automatic do_store(input logic [31:0] adr, input logic [31:0] data);
        @(negedge clk);
        MemWrite  = 1'b1;
        DataAdr   = adr;
        WriteData = data;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        DataAdr = adr;
        #1;
        chk(tag, ReadData, exp);
    endtask

    // Check the head entry, then pop it with a one-edge ready pulse.
    task automatic drain_one(input string tag, input logic [31:0] adr, input logic [31:0] data);
        chk({tag, "_valid"}, 32'(log_valid), 32'd1);
        chk({tag, "_adr"}, log_adr, adr);
        chk({tag, "_data"}, log_data, data);
        @(negedge clk);
        log_ready = 1'b1;
        @(posedge clk);
        #1;
        log_ready = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b0;
        MemWrite  = 1'b0;
        DataAdr   = 32'd0;
        WriteData = 32'd0;
        log_ready = 1'b0;
        #12;
        reset = 1'b1;
        #1;

        // Reset state
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_err", 32'(err_code), 32'd0);
        chk("rst_wrcnt", 32'(wr_count), 32'd0);
        chk("rst_lvalid", 32'(log_valid), 32'd0);
        chk("rst_ovf", 32'(log_overflow), 32'd0);
        chk("rst_ladr", log_adr, 32'd0);
        chk("rst_ldata", log_data, 32'd0);

        // Passing program with the consumer always ready
        @(negedge clk);
        log_ready = 1'b1;
        do_store(32'd96, 32'd10);
        chk("p_head1_valid", 32'(log_valid), 32'd1);
        chk("p_head1_adr", log_adr, 32'd96);
        chk("p_head1_data", log_data, 32'd10);
        chk("p_done_early", 32'(done), 32'd0);
        do_store(32'd100, 32'd7);
        chk("p_done", 32'(done), 32'd1);
        chk("p_pass", 32'(pass), 32'd1);
        chk("p_err", 32'(err_code), 32'd0);
        chk("p_wrcnt", 32'(wr_count), 32'd2);
        chk("p_head2_adr", log_adr, 32'd100);
        chk("p_head2_data", log_data, 32'd7);
        @(posedge clk);
        #1;
        chk("p_drained", 32'(log_valid), 32'd0);
        log_ready = 1'b0;
        rd_chk("p_ram24", 32'd96, 32'd10);
        do_store(32'd0, 32'd99);
        chk("p_ignore_cnt", 32'(wr_count), 32'd2);
        chk("p_ignore_log", 32'(log_valid), 32'd0);
        rd_chk("p_ignore_ram", 32'd96, 32'd10);

        // Async reset in PASS with entries pending; RAM must survive
        do_reset();
        do_store(32'd0, 32'h11);
        do_store(32'd4, 32'h22);
        do_store(32'd100, 32'd7);
        chk("ar_pass", 32'(pass), 32'd1);
        chk("ar_pending", 32'(log_valid), 32'd1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_done", 32'(done), 32'd0);
        chk("ar_pass0", 32'(pass), 32'd0);
        chk("ar_wrcnt", 32'(wr_count), 32'd0);
        chk("ar_lvalid", 32'(log_valid), 32'd0);
        chk("ar_ladr", log_adr, 32'd0);
        chk("ar_ldata", log_data, 32'd0);
        reset = 1'b1;
        rd_chk("ar_ram0", 32'd0, 32'h11);
        rd_chk("ar_ram1", 32'd4, 32'h22);
        rd_chk("ar_ram24", 32'd96, 32'd10);

        // Wrong result value, then later stores are ignored
        do_reset();
        do_store(32'd100, 32'd5);
        chk("wv_done", 32'(done), 32'd1);
        chk("wv_pass", 32'(pass), 32'd0);
        chk("wv_err", 32'(err_code), 32'd1);
        do_store(32'd96, 32'd3);
        chk("wv_wrcnt", 32'(wr_count), 32'd1);
        rd_chk("wv_ram24", 32'd96, 32'd10);
        chk("wv_log_adr", log_adr, 32'd100);
        chk("wv_log_data", log_data, 32'd5);

        // Out-of-range address (would alias word 0 if unchecked)
        do_reset();
        do_store(32'd256, 32'hAA);
        chk("or_done", 32'(done), 32'd1);
        chk("or_err", 32'(err_code), 32'd2);
        rd_chk("or_rd_zero", 32'd256, 32'd0);
        rd_chk("or_ram0", 32'd0, 32'h11);

        // Misaligned address
        do_reset();
        do_store(32'd98, 32'h55);
        chk("ma_err", 32'(err_code), 32'd3);
        chk("ma_wrcnt", 32'(wr_count), 32'd1);
        rd_chk("ma_ram24", 32'd96, 32'd10);

        // Store in flight while reset is low is discarded
        do_reset();
        do_store(32'd52, 32'h66);
        @(negedge clk);
        MemWrite  = 1'b1;
        DataAdr   = 32'd52;
        WriteData = 32'h77;
        reset     = 1'b0;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        reset    = 1'b1;
        chk("rs_wrcnt", 32'(wr_count), 32'd0);
        chk("rs_lvalid", 32'(log_valid), 32'd0);
        rd_chk("rs_ram13", 32'd52, 32'h66);

        // Overflow: six stores into a four-entry log with no consumer
        do_reset();
        for (int i = 0; i < 6; i++) begin
            do_store(32'(8 + 4 * i), 32'(32'h100 + i));
        end
        chk("ov_wrcnt", 32'(wr_count), 32'd6);
        chk("ov_flag", 32'(log_overflow), 32'd1);
        chk("ov_done", 32'(done), 32'd0);
        rd_chk("ov_ram7", 32'd28, 32'h105);
        for (int i = 0; i < 4; i++) begin
            drain_one($sformatf("ov_e%0d", i), 32'(8 + 4 * i), 32'(32'h100 + i));
        end
        chk("ov_empty", 32'(log_valid), 32'd0);
        chk("ov_sticky", 32'(log_overflow), 32'd1);

        // Full log, push and pop at the same edge
        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_store(32'(32 + 4 * i), 32'(32'h200 + i));
        end
        chk("fp_ovf_pre", 32'(log_overflow), 32'd0);
        @(negedge clk);
        log_ready = 1'b1;
        MemWrite  = 1'b1;
        DataAdr   = 32'd48;
        WriteData = 32'h204;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
        log_ready = 1'b0;
        chk("fp_ovf", 32'(log_overflow), 32'd0);
        chk("fp_wrcnt", 32'(wr_count), 32'd5);
        for (int i = 1; i < 5; i++) begin
            drain_one($sformatf("fp_e%0d", i), 32'(32 + 4 * i), 32'(32'h200 + i));
        end
        chk("fp_empty", 32'(log_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
